// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared sequencer state/mode types and default sweep limits
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_BLANK  = 3'd2,
    ST_LISTEN = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_SWEEP  = 2'd2
  } mode_t;

  localparam int DEF_ANGLE_MIN  = -30;
  localparam int DEF_ANGLE_MAX  = 30;
  localparam int DEF_ANGLE_STEP = 10;

  // Encoding 3 is unused and behaves as fixed-angle operation.
  function automatic mode_t decode_mode(input logic [1:0] m);
    mode_t r;
    case (m)
      2'd1:    r = MODE_SINGLE;
      2'd2:    r = MODE_SWEEP;
      default: r = MODE_FIXED;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/echo_window_detector.sv
// rtl/echo_window_detector.sv - first-crossing time-of-flight latch, hit flag and peak tracker
// Peak tracking is built only when SONAR_SWEEP_PEAK_EN is defined.
module echo_window_detector
  import sonar_pkg::*;
#(
  parameter int TW           = 24,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    en_in,
  input  logic                    clr_in,
  input  logic [TW-1:0]           t_in,
  input  logic [SAMPLE_WIDTH-1:0] threshold_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic                    hit_next_out,
  output logic [TW-1:0]           tof_next_out,
  output logic [SAMPLE_WIDTH-1:0] peak_next_out
);

  logic          hit_q, hit_d;
  logic [TW-1:0] tof_q, tof_d;
  logic          take;

  assign take = en_in && sample_valid_in;

  always_comb begin
    hit_d = hit_q;
    tof_d = tof_q;
    if (clr_in) begin
      hit_d = 1'b0;
      tof_d = '0;
    end else if (take && !hit_q && (sample_in > threshold_in)) begin
      hit_d = 1'b1;
      tof_d = t_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_q <= 1'b0;
      tof_q <= '0;
    end else begin
      hit_q <= hit_d;
      tof_q <= tof_d;
    end
  end

  // Next-state values let the caller capture a crossing on the last LISTEN cycle.
  assign hit_next_out = hit_d;
  assign tof_next_out = tof_d;

`ifdef SONAR_SWEEP_PEAK_EN
  logic [SAMPLE_WIDTH-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clr_in) begin
      peak_d = '0;
    end else if (take && (sample_in > peak_q)) begin
      peak_d = sample_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_next_out = peak_d;
`else
  assign peak_next_out = '0;
`endif

endmodule

// File: rtl/sonar_sweep_sequencer.sv
// rtl/sonar_sweep_sequencer.sv - sonar ping cadence, beam sweep and per-ping echo reporting
// Optional peak amplitude reporting is enabled with SONAR_SWEEP_PEAK_EN.
module sonar_sweep_sequencer
  import sonar_pkg::*;
#(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int BLANK_CYCLES  = 65536,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int ANGLE_WIDTH   = 8,
  parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
  parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
  parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
  localparam int TW           = $clog2(PERIOD_CYCLES)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    stop_in,
  input  logic [1:0]              mode_in,
  input  logic [ANGLE_WIDTH-1:0]  fixed_angle_in,
  input  logic [SAMPLE_WIDTH-1:0] threshold_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic                    burst_out,
  output logic                    burst_start_out,
  output logic                    listening_out,
  output logic [ANGLE_WIDTH-1:0]  beam_angle_out,
  output logic                    busy_out,
  output logic                    result_valid_out,
  output logic [ANGLE_WIDTH-1:0]  result_angle_out,
  output logic [TW-1:0]           result_tof_out,
  output logic                    result_hit_out,
  output logic [SAMPLE_WIDTH-1:0] result_peak_out,
  output logic                    sweep_done_out
);

  generate
    if (ANGLE_STEP <= 0 || ANGLE_MIN > ANGLE_MAX ||
        BURST_CYCLES + BLANK_CYCLES >= PERIOD_CYCLES - 1) begin : g_bad_params
      $error("sonar_sweep_sequencer: invalid ANGLE_* or cycle parameters");
    end
  endgenerate

  // One extra bit so angle + step cannot overflow at the sweep limit.
  typedef logic signed [ANGLE_WIDTH:0] angle_x_t;
  localparam angle_x_t A_MIN  = angle_x_t'(ANGLE_MIN);
  localparam angle_x_t A_MAX  = angle_x_t'(ANGLE_MAX);
  localparam angle_x_t A_STEP = angle_x_t'(ANGLE_STEP);

  localparam logic [TW-1:0] T_BURST_END  = TW'(BURST_CYCLES - 1);
  localparam logic [TW-1:0] T_BLANK_END  = TW'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [TW-1:0] T_LISTEN_END = TW'(PERIOD_CYCLES - 2);

  state_t                  state_q, state_d;
  logic [TW-1:0]           t_q, t_d;
  mode_t                   mode_q, mode_d, mode_new;
  logic [ANGLE_WIDTH-1:0]  angle_q, angle_d;
  logic                    stop_pend_q, stop_pend_d;
  angle_x_t                angle_step;
  logic                    sweep_end;

  logic                    burst_q, burst_d;
  logic                    burst_start_q, burst_start_d;
  logic                    listening_q, listening_d;
  logic                    busy_q, busy_d;
  logic                    result_valid_q, result_valid_d;
  logic [ANGLE_WIDTH-1:0]  result_angle_q, result_angle_d;
  logic [TW-1:0]           result_tof_q, result_tof_d;
  logic                    result_hit_q, result_hit_d;
  logic [SAMPLE_WIDTH-1:0] result_peak_q, result_peak_d;
  logic                    sweep_done_q, sweep_done_d;

  logic                    det_hit_next;
  logic [TW-1:0]           det_tof_next;
  logic [SAMPLE_WIDTH-1:0] det_peak_next;

  echo_window_detector #(
    .TW           (TW),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_detector (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .en_in           (state_q == ST_LISTEN),
    .clr_in          (burst_start_q),
    .t_in            (t_q),
    .threshold_in    (threshold_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .hit_next_out    (det_hit_next),
    .tof_next_out    (det_tof_next),
    .peak_next_out   (det_peak_next)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      t_q            <= '0;
      mode_q         <= MODE_FIXED;
      angle_q        <= '0;
      stop_pend_q    <= 1'b0;
      burst_q        <= 1'b0;
      burst_start_q  <= 1'b0;
      listening_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_angle_q <= '0;
      result_tof_q   <= '0;
      result_hit_q   <= 1'b0;
      result_peak_q  <= '0;
      sweep_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      mode_q         <= mode_d;
      angle_q        <= angle_d;
      stop_pend_q    <= stop_pend_d;
      burst_q        <= burst_d;
      burst_start_q  <= burst_start_d;
      listening_q    <= listening_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_angle_q <= result_angle_d;
      result_tof_q   <= result_tof_d;
      result_hit_q   <= result_hit_d;
      result_peak_q  <= result_peak_d;
      sweep_done_q   <= sweep_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    t_d        = t_q + TW'(1);
    mode_d     = mode_q;
    angle_d    = angle_q;
    mode_new   = decode_mode(mode_in);
    angle_step = angle_x_t'($signed(angle_q)) + A_STEP;
    sweep_end  = (mode_q != MODE_FIXED) && (angle_step > A_MAX);
    case (state_q)
      ST_IDLE: begin
        t_d = '0;
        if (start_in) begin
          state_d = ST_BURST;
          mode_d  = mode_new;
          angle_d = (mode_new == MODE_FIXED) ? fixed_angle_in : A_MIN[ANGLE_WIDTH-1:0];
        end
      end
      ST_BURST: begin
        if (t_q == T_BURST_END) begin
          state_d = (BLANK_CYCLES > 0) ? ST_BLANK : ST_LISTEN;
        end
      end
      ST_BLANK: begin
        if (t_q == T_BLANK_END) begin
          state_d = ST_LISTEN;
        end
      end
      ST_LISTEN: begin
        if (t_q == T_LISTEN_END) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        t_d = '0;
        if (stop_pend_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BURST;
          case (mode_q)
            MODE_SINGLE: begin
              if (sweep_end) begin
                state_d = ST_IDLE;
              end else begin
                angle_d = angle_step[ANGLE_WIDTH-1:0];
              end
            end
            MODE_SWEEP: begin
              angle_d = sweep_end ? A_MIN[ANGLE_WIDTH-1:0] : angle_step[ANGLE_WIDTH-1:0];
            end
            default: angle_d = fixed_angle_in;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    stop_pend_d = (state_d == ST_IDLE) ? 1'b0
                                       : (stop_pend_q || (stop_in && state_q != ST_IDLE));
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    burst_d        = (state_d == ST_BURST);
    burst_start_d  = (state_d == ST_BURST) && (state_q == ST_IDLE || state_q == ST_REPORT);
    listening_d    = (state_d == ST_LISTEN);
    busy_d         = (state_d != ST_IDLE);
    result_valid_d = (state_d == ST_REPORT);
    sweep_done_d   = result_valid_d && sweep_end && !stop_pend_d;
    result_angle_d = result_angle_q;
    result_tof_d   = result_tof_q;
    result_hit_d   = result_hit_q;
    result_peak_d  = result_peak_q;
    if (result_valid_d) begin
      result_angle_d = angle_q;
      result_tof_d   = det_tof_next;
      result_hit_d   = det_hit_next;
      result_peak_d  = det_peak_next;
    end
  end

  assign burst_out        = burst_q;
  assign burst_start_out  = burst_start_q;
  assign listening_out    = listening_q;
  assign beam_angle_out   = angle_q;
  assign busy_out         = busy_q;
  assign result_valid_out = result_valid_q;
  assign result_angle_out = result_angle_q;
  assign result_tof_out   = result_tof_q;
  assign result_hit_out   = result_hit_q;
  assign result_peak_out  = result_peak_q;
  assign sweep_done_out   = sweep_done_q;

endmodule

// File: tb/tb_sonar_sweep_sequencer.sv
// tb/tb_sonar_sweep_sequencer.sv - scoreboard bench for sonar_sweep_sequencer (honours SONAR_SWEEP_PEAK_EN)
module tb_sonar_sweep_sequencer;

  localparam int P  = 100;
  localparam int B  = 10;
  localparam int K  = 5;
  localparam int SW = 16;
  localparam int AW = 8;
  localparam int TW = $clog2(P);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in, stop_in, sample_valid_in;
  logic [1:0]    mode_in;
  logic [AW-1:0] fixed_angle_in;
  logic [SW-1:0] threshold_in, sample_in;
  logic          burst_out, burst_start_out, listening_out, busy_out;
  logic          result_valid_out, result_hit_out, sweep_done_out;
  logic [AW-1:0] beam_angle_out, result_angle_out;
  logic [TW-1:0] result_tof_out;
  logic [SW-1:0] result_peak_out;

  always #5 clk = ~clk;

  sonar_sweep_sequencer #(
    .PERIOD_CYCLES (P),
    .BURST_CYCLES  (B),
    .BLANK_CYCLES  (K),
    .SAMPLE_WIDTH  (SW),
    .ANGLE_WIDTH   (AW),
    .ANGLE_MIN     (-30),
    .ANGLE_MAX     (30),
    .ANGLE_STEP    (10)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .start_in         (start_in),
    .stop_in          (stop_in),
    .mode_in          (mode_in),
    .fixed_angle_in   (fixed_angle_in),
    .threshold_in     (threshold_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .burst_out        (burst_out),
    .burst_start_out  (burst_start_out),
    .listening_out    (listening_out),
    .beam_angle_out   (beam_angle_out),
    .busy_out         (busy_out),
    .result_valid_out (result_valid_out),
    .result_angle_out (result_angle_out),
    .result_tof_out   (result_tof_out),
    .result_hit_out   (result_hit_out),
    .result_peak_out  (result_peak_out),
    .sweep_done_out   (sweep_done_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  typedef struct {
    int angle;
    int tof;
    bit hit;
    int peak;
    bit done;
  } exp_t;

  exp_t sb[$];
  exp_t pop_e;
  int   held_tof = 0;

  function automatic bit in_listen(input int t);
    return (t >= B + K) && (t <= P - 2);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("done_alone", sweep_done_out & ~result_valid_out, 0);
      if (result_valid_out) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", result_valid_out, 0);
        end else begin
          pop_e = sb.pop_front();
          chk("res_angle", 32'($signed(result_angle_out)), pop_e.angle);
          chk("res_tof", result_tof_out, pop_e.tof);
          chk("res_hit", result_hit_out, pop_e.hit);
          chk("res_peak", result_peak_out, pop_e.peak);
          chk("res_done", sweep_done_out, pop_e.done);
        end
      end
    end
  end

  task automatic start_op(input logic [1:0] m, input int ang);
    @(negedge clk);
    mode_in        = m;
    fixed_angle_in = AW'(ang);
    start_in       = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("start_latency", burst_start_out, 1);
    chk("start_burst", burst_out, 1);
  endtask

  // Samples are given in time order; t < 0 means unused.
  task automatic play_ping(input int ang, input bit done, input bit cont,
                           input int stop_t, input int start_t,
                           input int ta, input int va, input int tb, input int vb,
                           input int tc, input int vc);
    exp_t e;
    int   ts[3];
    int   vs[3];
    int   waited;
    ts = '{ta, tb, tc};
    vs = '{va, vb, vc};
    e.angle = ang; e.tof = 0; e.hit = 1'b0; e.peak = 0; e.done = done;
    for (int i = 0; i < 3; i++) begin
      if (ts[i] >= 0 && in_listen(ts[i])) begin
        if (!e.hit && vs[i] > int'(threshold_in)) begin
          e.hit = 1'b1;
          e.tof = ts[i];
        end
`ifdef SONAR_SWEEP_PEAK_EN
        if (vs[i] > e.peak) e.peak = vs[i];
`endif
      end
    end
    sb.push_back(e);
    waited = 0;
    while (!burst_start_out && waited < 3 * P) begin
      @(negedge clk);
      waited++;
    end
    chk("burst_start_seen", burst_start_out, 1);
    for (int t = 0; t < P; t++) begin
      sample_valid_in = 1'b0;
      sample_in       = '0;
      stop_in         = (t == stop_t);
      start_in        = (t == start_t);
      mode_in         = 2'(t);
      for (int i = 0; i < 3; i++) begin
        if (ts[i] == t) begin
          sample_valid_in = 1'b1;
          sample_in       = SW'(vs[i]);
        end
      end
      chk("burst", burst_out, t < B);
      chk("burst_start", burst_start_out, t == 0);
      chk("listening", listening_out, in_listen(t));
      chk("beam_angle", 32'($signed(beam_angle_out)), ang);
      chk("busy", busy_out, 1);
      chk("report_cycle", result_valid_out, t == P - 1);
      if (t < P - 1) chk("tof_hold", result_tof_out, held_tof);
      @(negedge clk);
    end
    sample_valid_in = 1'b0;
    sample_in       = '0;
    stop_in         = 1'b0;
    start_in        = 1'b0;
    held_tof        = e.tof;
    if (cont) begin
      chk("cadence", burst_start_out, 1);
    end else begin
      chk("busy_fall", busy_out, 0);
      chk("idle_burst", burst_out, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_burst"}, burst_out, 0);
    chk({tag, "_bstart"}, burst_start_out, 0);
    chk({tag, "_listen"}, listening_out, 0);
    chk({tag, "_angle"}, beam_angle_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_rvalid"}, result_valid_out, 0);
    chk({tag, "_rangle"}, result_angle_out, 0);
    chk({tag, "_rtof"}, result_tof_out, 0);
    chk({tag, "_rhit"}, result_hit_out, 0);
    chk({tag, "_rpeak"}, result_peak_out, 0);
    chk({tag, "_done"}, sweep_done_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_in = 1'b0; stop_in = 1'b0; mode_in = 2'd0;
    fixed_angle_in = '0; threshold_in = 16'd1000; sample_in = '0; sample_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Fixed mode: basic hit, blank-window echo, multi-sample, end-of-listen boundary + stop.
    start_op(2'd0, 0);
    play_ping(0, 0, 1, -1, -1, 40, 2000, -1, 0, -1, 0);
    play_ping(0, 0, 1, -1, -1, 12, 5000, 30, 1000, -1, 0);
    fixed_angle_in = AW'(5);
    play_ping(0, 0, 1, -1, -1, 20, 1500, 30, 3000, 50, 2000);
    play_ping(5, 0, 0, 50, -1, 98, 1001, 99, 4000, -1, 0);

    // Single sweep ends on its own after the +30 ping.
    repeat (5) @(negedge clk);
    start_op(2'd1, 77);
    for (int i = 0; i < 7; i++) begin
      play_ping(-30 + 10 * i, i == 6, i != 6, -1, -1, 20 + i, 1200 + 100 * i, -1, 0, -1, 0);
    end
    for (int i = 0; i < 150; i++) begin
      chk("no_burst", burst_out, 0);
      chk("idle", busy_out, 0);
      @(negedge clk);
    end

    // Continuous sweep: stop in IDLE ignored, start while busy ignored, wrap, stop mid-ping.
    stop_in = 1'b1;
    @(negedge clk);
    stop_in = 1'b0;
    start_op(2'd2, 0);
    for (int i = 0; i < 8; i++) begin
      play_ping(-30 + 10 * (i % 7), i == 6, i != 7, (i == 7) ? 50 : -1, (i == 0) ? 60 : -1,
                30, 999 + i, -1, 0, -1, 0);
    end

    // Asynchronous reset in the middle of LISTEN, then restart from ANGLE_MIN.
    start_op(2'd0, 20);
    repeat (50) @(negedge clk);
    chk("pre_reset_listen", listening_out, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    held_tof = 0;
    @(negedge clk);
    rst = 1'b0;
    start_op(2'd2, 20);
    play_ping(-30, 0, 0, 50, -1, 40, 2000, -1, 0, -1, 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sonar_sweep_sequencer.md
# sonar_sweep_sequencer

Parametrised ping scheduler and echo ranger for the sonar front end. It generates the burst/blank/listen cadence and drives the beam angle, either fixed or stepped across a sweep. Per ping it detects the first threshold crossing on the beamformed receive stream and reports time-of-flight, hit flag and peak amplitude for that angle. It sits between the receive beamformer output and the range/velocity display path, and replaces the single-angle fixed-cadence burst logic.

## Interface
- PERIOD_CYCLES, 16777216, ping period in clocks (burst start to next burst start)
- BURST_CYCLES, 524288, transmit burst length in clocks
- BLANK_CYCLES, 65536, post-burst ring-down window; echoes ignored
- SAMPLE_WIDTH, 16, receive sample width (unsigned magnitude)
- ANGLE_WIDTH, 8, signed beam angle width (degrees)
- ANGLE_MIN, -30; ANGLE_MAX, 30; ANGLE_STEP, 10, sweep limits and step (degrees)
- TW = $clog2(PERIOD_CYCLES) is a derived localparam, not overridable
- Elaboration error unless ANGLE_STEP > 0, ANGLE_MIN <= ANGLE_MAX, and BURST_CYCLES+BLANK_CYCLES < PERIOD_CYCLES-1
- clk_in  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- start_in  in  1  pulse; starts operation when idle
- stop_in  in  1  pulse; requests stop at the end of the current ping
- mode_in  in  2  0 fixed, 1 single sweep, 2 continuous sweep; 3 treated as fixed
- fixed_angle_in  in  ANGLE_WIDTH  signed angle for fixed mode
- threshold_in  in  SAMPLE_WIDTH  echo threshold
- sample_in  in  SAMPLE_WIDTH  beamformed receive sample
- sample_valid_in  in  1  sample qualifier
- burst_out  out  1  high during burst; gates transmitters
- burst_start_out  out  1  one-cycle pulse on the first burst cycle; clears downstream state
- listening_out  out  1  high during LISTEN
- beam_angle_out  out  ANGLE_WIDTH  signed current angle
- busy_out  out  1  high whenever not IDLE
- result_valid_out  out  1  one-cycle pulse per ping
- result_angle_out  out  ANGLE_WIDTH  angle of the reported ping
- result_tof_out  out  TW  timer value at the first crossing; 0 if no hit
- result_hit_out  out  1  echo detected this ping
- result_peak_out  out  SAMPLE_WIDTH  max valid sample seen in LISTEN
- sweep_done_out  out  1  one-cycle pulse when a sweep completes

## Operation
- States: IDLE, BURST, BLANK, LISTEN, REPORT.
- Ping timer t runs from 0 to PERIOD_CYCLES-1 and clears to 0 on entry to BURST.
- IDLE + start_in: latch mode_in and, in fixed mode, fixed_angle_in; otherwise angle = ANGLE_MIN. Go to BURST.
- BURST covers t in 0..BURST_CYCLES-1.
- BLANK covers t in BURST_CYCLES..BURST_CYCLES+BLANK_CYCLES-1.
- LISTEN runs from the end of BLANK to t = PERIOD_CYCLES-2.
- REPORT is the single cycle at t = PERIOD_CYCLES-1.
- Echo detection applies in LISTEN only. The first cycle with sample_valid_in && sample_in > threshold_in (unsigned, strict) latches tof = t and sets hit. Later crossings do not change tof.
- Peak is an unsigned max over valid LISTEN samples. It clears at burst start.
- After REPORT:
  - If stop is pending: go to IDLE.
  - Fixed mode: re-sample fixed_angle_in, then BURST.
  - Single sweep: if angle+ANGLE_STEP > ANGLE_MAX, pulse sweep_done and go to IDLE; else step the angle, then BURST.
  - Continuous sweep: same test, but wrap to ANGLE_MIN, pulse sweep_done, and continue.
- Angle arithmetic uses ANGLE_WIDTH+1 bits signed so there is no overflow at the limit.
- stop_in sets a sticky pending flag whenever busy; the flag clears on entry to IDLE. stop_in in IDLE is ignored.
- start_in while busy is ignored. mode_in changes while busy are ignored.

## Timing
- Reset (asynchronous) forces IDLE and sets every output and internal register to 0, including beam_angle_out.
- All outputs are registered.
- start_in at cycle k: burst_out and burst_start_out are high at cycle k+1.
- Cadence is exactly PERIOD_CYCLES between consecutive burst_start_out pulses.
- result_valid_out, result_* and sweep_done_out assert in the REPORT cycle. result_* hold until the next REPORT.
- A crossing in the REPORT cycle or in BLANK is ignored.
- A crossing at t = PERIOD_CYCLES-2 is counted.
- beam_angle_out changes only in the cycle that burst_start_out asserts, so it is stable for the whole ping.
- busy_out falls in the cycle after REPORT when the next state is IDLE.

## Configuration
- SONAR_SWEEP_PEAK_EN defined: peak tracking is built and result_peak_out is valid.
- SONAR_SWEEP_PEAK_EN undefined: the peak register is omitted and result_peak_out is constant 0. All other behaviour is identical.

## Structure
- Shared sonar_pkg holds:
  - the state enum;
  - the mode enum (MODE_FIXED, MODE_SINGLE, MODE_SWEEP);
  - default angle limit and step constants.
- Sub-module echo_window_detector handles threshold crossing, the tof latch, the hit flag and peak tracking. It takes an enable input (LISTEN) and a clear input (burst start).

## Test plan
- Params PERIOD=100, BURST=10, BLANK=5:
  - Fixed mode, angle 0, threshold 1000, sample 2000 valid at t=40 -> burst_out high t0-9; REPORT at t=99 with tof=40, hit=1, angle=0.
  - Sample 5000 at t=12 (BLANK) and no other -> hit=0, tof=0.
- Single sweep -> 7 results at angles -30,-20,...,30; sweep_done with the 30° result; busy_out low the next cycle; no further bursts.
- Continuous sweep -> angle wraps from 30 to -30 with sweep_done every 7 pings; stop_in at t=50 -> that ping still reports, then IDLE.
- Reset asserted mid-LISTEN -> all outputs 0 immediately, without a clock edge; new start_in restarts from angle -30.
- Samples 1500, 3000, 2000 in LISTEN with threshold 1000 -> tof at the 1500 sample, peak 3000 with SONAR_SWEEP_PEAK_EN defined, peak 0 without it.
